// File: rtl/fc_pkg.sv
// Shared constants and types for the fully-connected layer and its output streamer.
package fc_pkg;

  localparam int unsigned DATA_W   = 16;
  localparam int unsigned N_OUT    = 32;
  localparam int unsigned IDX_W    = 5;
  localparam int unsigned SIGN_BIT = DATA_W - 1;

  typedef enum logic [1:0] {
    StIdle,
    StStream,
    StDone
  } state_e;

endpackage

// File: rtl/fc_relu_streamer_if.sv
// Capture, element-stream and argmax signals of the ReLU streamer.
interface fc_relu_streamer_if;
  import fc_pkg::*;

  logic                    in_valid;
  logic [DATA_W*N_OUT-1:0] output_fc;
  logic                    in_ready;
  logic                    out_valid;
  logic                    out_ready;
  logic [DATA_W-1:0]       out_data;
  logic [IDX_W-1:0]        out_index;
  logic                    out_last;
  logic                    argmax_valid;
  logic [IDX_W-1:0]        argmax_idx;
  logic [DATA_W-1:0]       argmax_val;

  // Streamer side
  modport slave (
    input  in_valid, output_fc, out_ready,
    output in_ready, out_valid, out_data, out_index, out_last,
    output argmax_valid, argmax_idx, argmax_val
  );

  // Producer / consumer side
  modport master (
    output in_valid, output_fc, out_ready,
    input  in_ready, out_valid, out_data, out_index, out_last,
    input  argmax_valid, argmax_idx, argmax_val
  );

endinterface

// File: rtl/relu16.sv
// Sign-bit clamp: any element with the sign bit set (including -0 and negative NaN) becomes zero.
module relu16
  import fc_pkg::*;
(
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);

  // Clamp negatives to all-zero, pass everything else unchanged
  always_comb begin
    dout = din[SIGN_BIT] ? '0 : din;
  end

endmodule

// File: rtl/fc_relu_streamer.sv
// Captures one layer result through ReLU, streams it element by element and tracks the argmax.
module fc_relu_streamer #(
  parameter int unsigned DATA_W = fc_pkg::DATA_W,
  parameter int unsigned N_OUT  = fc_pkg::N_OUT,
  parameter int unsigned IDX_W  = fc_pkg::IDX_W
) (
  input logic               clk,
  input logic               reset,
  fc_relu_streamer_if.slave bus
);
  import fc_pkg::state_e;
  import fc_pkg::StIdle;
  import fc_pkg::StStream;
  import fc_pkg::StDone;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] buf_q [N_OUT];
  logic [DATA_W-1:0] relu_out [N_OUT];
  logic [IDX_W-1:0]  count_q;
  logic [IDX_W-1:0]  max_idx_q;
  logic [DATA_W-1:0] max_val_q;
  logic              accept;
  logic              handshake;
  logic              last_elem;
  logic [DATA_W-1:0] cur_data;

  for (genvar i = 0; i < N_OUT; i++) begin : g_relu
    relu16 u_relu (
      .din  (bus.output_fc[DATA_W*i +: DATA_W]),
      .dout (relu_out[i])
    );
  end

  // Handshake qualifiers shared by the FSM and the datapath
  always_comb begin
    accept    = (state_q == StIdle) && bus.in_valid;
    handshake = (state_q == StStream) && bus.out_ready;
    last_elem = (count_q == IDX_W'(N_OUT - 1));
    cur_data  = buf_q[count_q];
  end

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (accept) state_d = StStream;
      StStream: if (handshake && last_elem) state_d = StDone;
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // FSM outputs; data outputs read as zero outside STREAM
  always_comb begin
    bus.in_ready     = (state_q == StIdle);
    bus.out_valid    = (state_q == StStream);
    bus.out_data     = (state_q == StStream) ? cur_data : '0;
    bus.out_index    = (state_q == StStream) ? count_q : '0;
    bus.out_last     = (state_q == StStream) && last_elem;
    bus.argmax_valid = (state_q == StDone);
    bus.argmax_idx   = max_idx_q;
    bus.argmax_val   = max_val_q;
  end

  // Capture buffer: loaded once per frame with the activated elements
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_OUT; i++) begin
        buf_q[i] <= '0;
      end
    end else if (accept) begin
      for (int i = 0; i < N_OUT; i++) begin
        buf_q[i] <= relu_out[i];
      end
    end
  end

  // Element counter; cleared after the last handshake so the next frame starts at 0
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (handshake) begin
      count_q <= last_elem ? '0 : count_q + IDX_W'(1);
    end
  end

  // Running argmax; activated values are non-negative so an unsigned compare orders them,
  // and strict greater-than keeps the lowest index on ties
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      max_idx_q <= '0;
      max_val_q <= '0;
    end else if (handshake && ((count_q == '0) || (cur_data > max_val_q))) begin
      max_idx_q <= count_q;
      max_val_q <= cur_data;
    end
  end

endmodule
